// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: PC/latch enable and per-latch valid sequencing with run, single-step and halt drain.
//   Ports: i_clock, i_reset (sync, active-high), i_run, i_step, i_stall_req, i_flush_req, i_halt_id;
//   o_pc_en, o_latch_en[N_STAGES-2:0], o_valid[N_STAGES-2:0], o_halt, o_running, o_cycle_count[NB_CYCLE-1:0].
//   Optional macro PIPE_CYCLE_CNT_EN builds the saturating advance counter; otherwise o_cycle_count is 0.
module pipeline_sequencer #(
    parameter int N_STAGES = 5,
    parameter int NB_CYCLE = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic                  i_stall_req,
    input  logic                  i_flush_req,
    input  logic                  i_halt_id,
    output logic                  o_pc_en,
    output logic [N_STAGES-2:0]   o_latch_en,
    output logic [N_STAGES-2:0]   o_valid,
    output logic                  o_halt,
    output logic                  o_running,
    output logic [NB_CYCLE-1:0]   o_cycle_count
);
    localparam int L = N_STAGES - 1;
    typedef enum logic [1:0] {ACTIVE, DRAIN, HALTED} state_t;
    state_t state_q, state_d;
    logic step_d_q;
    logic [L-1:0] valid_q, valid_d;
    logic [L-1:1] tok_q, tok_d;
    logic halt_q, halt_d;
    logic adv, active, stall, flush, halt_req, halt_acc;
    assign active    = state_q == ACTIVE;
    assign adv       = (state_q != HALTED) & (i_run | (i_step & ~step_d_q));
    assign stall     = adv & i_stall_req & valid_q[0];
    assign flush     = adv & i_flush_req & valid_q[0];
    assign halt_req  = adv & i_halt_id & valid_q[0];
    assign halt_acc  = halt_req & ~stall;
    assign o_pc_en    = adv & active & ~stall;
    assign o_latch_en = {{(L-1){adv}}, o_pc_en};
    assign o_running  = adv;
    assign o_valid    = valid_q;
    assign o_halt     = halt_q;
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tok_d   = tok_q;
        halt_d  = halt_q;
        if (adv) begin
            // A stall keeps the ID slot and pushes a bubble into ID/EX instead.
            valid_d[0] = stall ? valid_q[0] : active & ~flush & ~halt_req;
            valid_d[1] = valid_q[0] & ~stall;
            for (int k = 2; k < L; k++) valid_d[k] = valid_q[k-1];
            tok_d[1] = halt_acc;
            for (int k = 2; k < L; k++) tok_d[k] = tok_q[k-1];
            if (halt_acc) state_d = DRAIN;
            // The token in MEM/WB retires on this advance: the pipeline is empty afterwards.
            if (state_q == DRAIN && tok_q[L-1]) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ACTIVE;
            step_d_q <= 1'b0;
            valid_q  <= '0;
            tok_q    <= '0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_d_q <= i_step;
            valid_q  <= valid_d;
            tok_q    <= tok_d;
            halt_q   <= halt_d;
        end
    end
`ifdef PIPE_CYCLE_CNT_EN
    logic [NB_CYCLE-1:0] cnt_q, cnt_d;
    assign cnt_d = (adv && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    assign o_cycle_count = cnt_q;
    always_ff @(posedge i_clock) begin
        if (i_reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign o_cycle_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: scoreboard bench driving directed and random stimulus against an instruction-tag pipeline model.
module tb_pipeline_sequencer;
    localparam int N = 5;
    localparam int L = N - 1;
    logic clk = 1'b0;
    logic rst, run, step, stall_req, flush_req, halt_id;
    logic pc_en, halt, running;
    logic [L-1:0] latch_en, valid;
    logic [31:0] cycle_count;
    pipeline_sequencer #(.N_STAGES(N), .NB_CYCLE(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_run(run), .i_step(step),
        .i_stall_req(stall_req), .i_flush_req(flush_req), .i_halt_id(halt_id),
        .o_pc_en(pc_en), .o_latch_en(latch_en), .o_valid(valid), .o_halt(halt),
        .o_running(running), .o_cycle_count(cycle_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic pc_en;
        logic [L-1:0] le;
        logic run;
        logic [L-1:0] v;
        logic h;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    bit stim_done = 0;
    // Model: each latch holds an instruction tag (0 = bubble).
    int pipe[L];
    int next_tag, halt_tag;
    bit draining, halted, prev_step;
    longint cnt;
    bit p_adv, p_st, p_fl, p_hl, p_rst, p_step;
    task automatic model_reset();
        for (int k = 0; k < L; k++) pipe[k] = 0;
        draining = 0; halted = 0; prev_step = 0; cnt = 0; halt_tag = 0; next_tag = 1;
    endtask
    task automatic model_edge();
        int np[L];
        bit retire;
        if (p_rst) begin
            model_reset();
            return;
        end
        prev_step = p_step;
        if (!p_adv) return;
        retire = draining && pipe[L-1] == halt_tag;
        for (int k = 2; k < L; k++) np[k] = pipe[k-1];
        if (p_st) begin
            np[0] = pipe[0];
            np[1] = 0;
        end else begin
            np[1] = pipe[0];
            if (!draining && !p_fl && !p_hl) begin
                np[0] = next_tag;
                next_tag++;
            end else np[0] = 0;
            if (p_hl) begin
                draining = 1;
                halt_tag = pipe[0];
            end
        end
        for (int k = 0; k < L; k++) pipe[k] = np[k];
        if (retire) halted = 1;
        if (cnt < 64'hFFFF_FFFF) cnt++;
    endtask
    task automatic cyc(input bit r, input bit s, input bit st, input bit fl, input bit h, input bit rs);
        exp_t e;
        bit v0;
        run = r; step = s; stall_req = st; flush_req = fl; halt_id = h; rst = rs;
        v0 = pipe[0] != 0;
        p_adv = !halted && (r || (s && !prev_step));
        p_st = p_adv && st && v0;
        p_fl = p_adv && fl && v0;
        p_hl = p_adv && h && v0;
        p_rst = rs; p_step = s;
        e.run = p_adv;
        e.pc_en = p_adv && !draining && !p_st;
        e.le = p_adv ? {L{1'b1}} : '0;
        e.le[0] = e.pc_en;
        for (int k = 0; k < L; k++) e.v[k] = pipe[k] != 0;
        e.h = halted;
`ifdef PIPE_CYCLE_CNT_EN
        e.cnt = cnt[31:0];
`else
        e.cnt = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en", {31'b0, pc_en}, {31'b0, e.pc_en});
                chk("latch_en", {28'b0, latch_en}, {28'b0, e.le});
                chk("running", {31'b0, running}, {31'b0, e.run});
                chk("valid", {28'b0, valid}, {28'b0, e.v});
                chk("halt", {31'b0, halt}, {31'b0, e.h});
                chk("cycle_count", cycle_count, e.cnt);
            end
        end
    end
    initial begin : driver
        rst = 1; run = 0; step = 0; stall_req = 0; flush_req = 0; halt_id = 0;
        model_reset();
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 1);
        repeat (6) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        repeat (8) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                         $urandom_range(0, 20) == 0, $urandom_range(0, 60) == 0);
        stim_done = 1;
    end
    initial begin : finisher
        int guard = 0;
        wait (stim_done);
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Parametrised pipeline sequencer for the N-stage DLX/MIPS core. It owns the PC write enable and every inter-stage latch enable, and tracks a per-latch valid bit so that bubbles, branch flushes and halt drain are explicit rather than implied by control-word zeroing. It supports free-run and debug-unit single-step modes, and raises a registered halt only once the halt token has retired through the last stage. It sits beside the stage modules in the pipeline top and replaces the scattered `pc_write`/`IF_ID_write`/`enable_pipe` gating.

## Interface
- `N_STAGES`, 5: pipeline stage count (IF..WB); minimum 3; latch count is `N_STAGES-1`.
- `NB_CYCLE`, 32: width of the retired-cycle counter.

- `i_clock` input 1: clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_run` input 1: level; advance the pipeline every cycle while high.
- `i_step` input 1: debug single step; each rising edge produces exactly one advance.
- `i_stall_req` input 1: load-use hazard from ID; hold PC and IF/ID, insert a bubble into ID/EX.
- `i_flush_req` input 1: taken branch/jump resolved in ID; squash the IF/ID slot.
- `i_halt_id` input 1: the instruction in ID is HALT.
- `o_pc_en` output 1: PC register write enable.
- `o_latch_en` output `N_STAGES-1`: bit k enables latch k (0 = IF/ID, `N_STAGES-2` = MEM/WB).
- `o_valid` output `N_STAGES-1`: bit k = latch k holds a real instruction; downstream gates writes with it.
- `o_halt` output 1: the pipeline has drained after HALT.
- `o_running` output 1: an advance is occurring this cycle.
- `o_cycle_count` output `NB_CYCLE`: number of advances since reset.

## Operation
- FSM states: ACTIVE (fetching), DRAIN (fetch stopped, halt token in flight), HALTED.
- Step edge detect: `step = i_step & ~step_d`. `step_d` is registered every cycle, including when the FSM is not advancing.
- Advance: `adv = (state != HALTED) & (i_run | step)`. `o_running = adv`.
- Qualified requests: `stall = i_stall_req & o_valid[0]`, `flush = i_flush_req & o_valid[0]`, `halt = i_halt_id & o_valid[0]`. All requests are ignored when `adv = 0`.
- Enables with `adv = 0`: all zero.
- Enables in ACTIVE with `adv = 1`:
  - `o_pc_en = ~stall`.
  - `o_latch_en[0] = ~stall`.
  - `o_latch_en[k>=1] = 1`.
- Enables in DRAIN with `adv = 1`:
  - `o_pc_en = 0`.
  - `o_latch_en[0] = 0`.
  - `o_latch_en[k>=1] = 1`.
- Valid update on `adv`:
  - `valid[0]`: holds on stall. Otherwise it loads `(state==ACTIVE) & ~flush & ~halt`.
  - `valid[1]`: loads `valid[0] & ~stall`.
  - `valid[k>=2]`: loads `valid[k-1]`.
- Priority: stall over flush over halt. While stalled, flush and halt are not consumed; ID holds, so they are re-presented on the next cycle.
- Halt token: on `adv & halt & ~stall`, `tok[1] <= 1` and the state goes to DRAIN. `tok[k] <= tok[k-1]` on each `adv`.
- DRAIN to HALTED: on `adv` when `tok[N_STAGES-2] = 1`, i.e. the HALT leaves WB. `o_halt <= 1` on the same edge.
- HALTED is exited only by reset.
- Cycle counter: increments on `adv` and saturates at all-ones.

## Timing
- Reset (takes priority over everything, including mid-DRAIN):
  - state ACTIVE.
  - `valid`, `tok`, `step_d` all 0.
  - `o_cycle_count` 0, `o_halt` 0.
  - `o_pc_en`, `o_latch_en`, `o_running` are 0 unless `i_run` is high in the first post-reset cycle.
- `o_pc_en`, `o_latch_en` and `o_running` are combinational from state and inputs, and act on the same edge.
- `o_valid`, `o_halt` and `o_cycle_count` are registered and change one edge after the advance that causes them.
- Halt latency: `o_halt` rises exactly `N_STAGES-1` advances after the HALT is accepted in ID. With `N_STAGES = 5` that is 4 advances. Paused cycles stretch the latency but do not add to the advance count.
- Step and run together: one advance per cycle, never two.
- `i_step` held high: exactly one advance.
- Stall release: the bubble occupies exactly one slot per stalled cycle.

## Configuration
- `PIPE_CYCLE_CNT_EN`:
  - Defined: `o_cycle_count` behaves as specified above.
  - Undefined: the counter register is not built and `o_cycle_count` is tied to 0.

## Test plan
- Free run: reset, then `i_run = 1` for 6 cycles with no requests. Expect `o_valid` to fill as 0001, 0011, 0111, 1111, and `o_cycle_count = 6`.
- Load-use stall: `i_stall_req` for 1 cycle with `valid[0] = 1`. Expect `o_pc_en = 0` and `o_latch_en = 1110` that cycle, then `valid[1] = 0` on the next edge, and no lost instruction.
- Stall and flush together: both asserted in cycle t. Expect the stall behaviour in t; at t+1 (still asserting flush) expect `valid[0] <= 0` and `o_pc_en = 1`.
- Halt drain with `N_STAGES = 5`: `i_halt_id` in free run. Expect `o_pc_en = 0` from the next cycle, `o_halt = 1` exactly 4 advances later, and all enables 0 thereafter.
- Single step: `i_run = 0`, `i_step` held high for 3 cycles, then two 1-cycle pulses. Expect exactly 3 advances (`o_cycle_count = 3`) and `o_running` high for 3 single cycles.
- Reset mid-DRAIN: assert `i_reset` with `tok[2] = 1`. Expect state ACTIVE, `o_valid = 0`, `o_halt = 0` and `o_cycle_count = 0` next cycle. Rebuild without `PIPE_CYCLE_CNT_EN` and expect `o_cycle_count = 0` throughout.
